ov_init_seq: RTL and testbench

- Power-up and register-initialisation sequencer for the OV camera sensor.
- After a start pulse it waits a power-up delay. It then walks a 16-bit command table and issues one SCCB/I2C register write per entry through the existing iic register interface (devid/addr/wdata plus a write action strobe).
- Table entries can also request millisecond delays.
- Sits inside the camera interface level, alongside the iic engine. It owns the iic engine while busy; the host fx-bus path is muxed out using own_iic.

---
 rtl/ov_pkg.sv | 16 +
 rtl/ov_ms_timer.sv | 38 +++
 rtl/ov_init_seq.sv | 153 +++++++++++++++
 tb/tb_ov_init_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov_pkg.sv
// Shared definitions for the OV sensor init sequencer: state encoding,
// command-table markers and iic status bit positions.
package ov_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_STROBE,
    S_WAIT_HI, S_WAIT_LO, S_DELAY, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0]  DLY_TAG  = 8'hFF;
  localparam logic [15:0] END_WORD = 16'hFFFF;

  localparam int BUSY = 0;
  localparam int NACK = 1;

endpackage

// File: rtl/ov_ms_timer.sv
// Millisecond down-counter driven by a microsecond pulse; owns the us->ms prescaler.
module ov_ms_timer #(
  parameter int US_PER_MS = 1000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] ms_val,
  input  logic       pluse_us,
  output logic       expired
);

  localparam int UW = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;

  logic [7:0]    ms_cnt;
  logic [UW-1:0] us_cnt;

  // A load restarts the prescaler so a delay is never shortened by a partial ms.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ms_cnt <= '0;
      us_cnt <= '0;
    end else if (load) begin
      ms_cnt <= ms_val;
      us_cnt <= '0;
    end else if (pluse_us && ms_cnt != 8'd0) begin
      if (us_cnt == UW'(US_PER_MS - 1)) begin
        us_cnt <= '0;
        ms_cnt <= ms_cnt - 8'd1;
      end else begin
        us_cnt <= us_cnt + UW'(1);
      end
    end
  end

  assign expired = (ms_cnt == 8'd0);

endmodule

// File: rtl/ov_init_seq.sv
// Power-up and register-initialisation sequencer for the OV camera sensor:
// walks a command table and issues SCCB writes through the iic engine.
module ov_init_seq
  import ov_pkg::*;
#(
  parameter logic [7:0] DEVID     = 8'h42,
  parameter int         TBL_AW    = 6,
  parameter int         PWRUP_MS  = 20,
  parameter int         US_PER_MS = 1000,
  parameter int         MAX_RETRY = 3,
  parameter int         ACK_TMO   = 64
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic [7:0]        cfg_iic_devid,
  output logic [7:0]        cfg_iic_addr,
  output logic [7:0]        cfg_iic_wdata,
  output logic [7:0]        act_iic_write,
  input  logic [7:0]        stu_iic_status,
  output logic              own_iic,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(ACK_TMO) + 1;

  state_t        state;
  logic          strobe;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmo;
  logic          start_ok, is_end, is_dly, tmr_load, expired;
  logic [7:0]    tmr_val;
  logic          unused_status;

  assign cfg_iic_devid = DEVID;
  assign act_iic_write = {7'd0, strobe};
  assign own_iic       = seq_busy;
  assign unused_status = ^stu_iic_status[7:2];

  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign is_end   = (tbl_data == END_WORD);
  assign is_dly   = (tbl_data[15:8] == DLY_TAG);

  // The timer load is combinational so PWRUP/DELAY see the new count on their first cycle.
  assign tmr_load = start_ok || (state == S_DECODE && !is_end && is_dly);
  assign tmr_val  = start_ok ? 8'(PWRUP_MS) : tbl_data[7:0];

  ov_ms_timer #(.US_PER_MS(US_PER_MS)) u_timer (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (tmr_load),
    .ms_val  (tmr_val),
    .pluse_us(pluse_us),
    .expired (expired)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state         <= S_IDLE;
      tbl_addr      <= '0;
      cfg_iic_addr  <= '0;
      cfg_iic_wdata <= '0;
      strobe        <= 1'b0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      seq_err       <= 1'b0;
      err_idx       <= '0;
      retry         <= '0;
      tmo           <= '0;
    end else begin
      strobe <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          state    <= S_PWRUP;
          tbl_addr <= '0;
          seq_busy <= 1'b1;
          seq_done <= 1'b0;
          seq_err  <= 1'b0;
          retry    <= '0;
        end
        S_PWRUP: if (expired) state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (is_end) begin
            state    <= S_DONE;
            seq_busy <= 1'b0;
            seq_done <= 1'b1;
          end else if (is_dly) begin
            state <= S_DELAY;
          end else begin
            cfg_iic_addr  <= tbl_data[15:8];
            cfg_iic_wdata <= tbl_data[7:0];
            strobe        <= 1'b1;
            state         <= S_STROBE;
          end
        end
        S_STROBE: begin
          tmo   <= '0;
          state <= S_WAIT_HI;
        end
        // The strobe cycle counts as the first cycle of the ack window.
        S_WAIT_HI: begin
          if (stu_iic_status[BUSY]) begin
            state <= S_WAIT_LO;
          end else if (tmo == TW'(ACK_TMO - 2)) begin
            state    <= S_ERR;
            seq_busy <= 1'b0;
            seq_err  <= 1'b1;
            err_idx  <= tbl_addr;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_WAIT_LO: if (!stu_iic_status[BUSY]) begin
          if (!stu_iic_status[NACK]) begin
            retry <= '0;
            state <= S_NEXT;
          end else if (retry < RW'(MAX_RETRY)) begin
            retry  <= retry + RW'(1);
            strobe <= 1'b1;
            state  <= S_STROBE;
          end else begin
            state    <= S_ERR;
            seq_busy <= 1'b0;
            seq_err  <= 1'b1;
            err_idx  <= tbl_addr;
          end
        end
        S_DELAY: if (expired) state <= S_NEXT;
        // The last table slot is an implicit end marker.
        S_NEXT: begin
          if (tbl_addr == '1) begin
            state    <= S_DONE;
            seq_busy <= 1'b0;
            seq_done <= 1'b1;
          end else begin
            tbl_addr <= tbl_addr + TBL_AW'(1);
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov_init_seq.sv
// Directed bench for ov_init_seq with a synchronous table ROM and a simple iic engine model.
module tb_ov_init_seq;

  localparam int TBL_AW  = 2;
  localparam int ACK_TMO = 16;
  localparam int ACK_DLY = 10;

  logic              clk_sys = 1'b0;
  logic              rst, start;
  logic              pluse_us = 1'b0;
  logic [TBL_AW-1:0] tbl_addr, err_idx;
  logic [15:0]       tbl_data;
  logic [7:0]        cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata, act_iic_write, stu_iic_status;
  logic              own_iic, seq_busy, seq_done, seq_err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk_sys = ~clk_sys;

  ov_init_seq #(
    .DEVID(8'h42), .TBL_AW(TBL_AW), .PWRUP_MS(2), .US_PER_MS(4),
    .MAX_RETRY(3), .ACK_TMO(ACK_TMO)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cfg_iic_devid(cfg_iic_devid), .cfg_iic_addr(cfg_iic_addr),
    .cfg_iic_wdata(cfg_iic_wdata), .act_iic_write(act_iic_write),
    .stu_iic_status(stu_iic_status), .own_iic(own_iic), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_err(seq_err), .err_idx(err_idx)
  );

  // Table ROM with one cycle of read latency.
  logic [15:0] rom [0:3];
  always @(posedge clk_sys) tbl_data <= rom[tbl_addr];

  // Microsecond pulse every 10 clocks, with a running pulse count.
  int pc = 0;
  int pulse_total = 0;
  always @(posedge clk_sys) begin
    if (pc == 9) begin pc <= 0; pluse_us <= 1'b1; end
    else begin pc <= pc + 1; pluse_us <= 1'b0; end
    if (pluse_us) pulse_total <= pulse_total + 1;
  end

  // iic engine model: busy for ACK_DLY+1 cycles after a strobe; NACK/no-response by strobe number.
  int         strobe_n   = 0;
  int         nack_until = 0;
  int         noresp_at  = 1000;
  int         bcnt       = 0;
  int         hi_bits    = 0;
  logic       ib_busy    = 1'b0;
  logic       ib_nack    = 1'b0;
  logic [7:0] log_addr [0:63];
  logic [7:0] log_data [0:63];
  int         log_pulse [0:63];
  int         fall_pulse [0:63];

  assign stu_iic_status = {6'd0, ib_nack, ib_busy};

  always @(posedge clk_sys) begin
    if (act_iic_write[7:1] != 7'd0) hi_bits <= hi_bits + 1;
    if (rst) begin
      ib_busy <= 1'b0;
      ib_nack <= 1'b0;
    end else if (act_iic_write[0]) begin
      log_addr[strobe_n]  <= cfg_iic_addr;
      log_data[strobe_n]  <= cfg_iic_wdata;
      log_pulse[strobe_n] <= pulse_total;
      strobe_n            <= strobe_n + 1;
      if (strobe_n < noresp_at) begin
        ib_busy <= 1'b1;
        bcnt    <= ACK_DLY;
        ib_nack <= (strobe_n < nack_until);
      end
    end else if (ib_busy) begin
      if (bcnt == 0) begin
        ib_busy                  <= 1'b0;
        fall_pulse[strobe_n - 1] <= pulse_total;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(seq_done || seq_err) && n < 3000) begin @(negedge clk_sys); n++; end
    chk({tag, "_end_tmo"}, 32'(n < 3000), 1);
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!act_iic_write[0] && n < 2000) begin @(negedge clk_sys); n++; end
    chk({tag, "_strobe_tmo"}, 32'(n < 2000), 1);
  endtask

  task automatic load_rom(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    int s0, p0, gap, n;
    rst = 1'b1; start = 1'b0;
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    repeat (3) @(negedge clk_sys);
    chk("rst_busy", seq_busy, 0);
    chk("rst_own", own_iic, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_act", act_iic_write, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_devid", cfg_iic_devid, 8'h42);
    rst = 1'b0;

    // Nominal: two writes then end marker.
    s0 = strobe_n; p0 = pulse_total;
    pulse_start();
    chk("nom_own_busy", own_iic, 1);
    wait_end("nom");
    chk("nom_strobes", strobe_n - s0, 2);
    chk("nom_w0", {log_addr[s0], log_data[s0]}, 16'h1280);
    chk("nom_w1", {log_addr[s0+1], log_data[s0+1]}, 16'h1101);
    chk("nom_pwrup_gap", 32'(log_pulse[s0] - p0 >= 8), 1);
    chk("nom_done", seq_done, 1);
    chk("nom_tbl_addr", tbl_addr, 2);
    chk("nom_own_low", own_iic, 0);

    // Delay entry of 3 ms; a start pulse during the delay must be ignored.
    load_rom(16'h1280, 16'hFF03, 16'h1101, 16'hFFFF);
    s0 = strobe_n;
    pulse_start();
    wait_strobe("dly");
    repeat (30) @(negedge clk_sys);
    pulse_start();
    wait_end("dly");
    chk("dly_strobes", strobe_n - s0, 2);
    chk("dly_w1", {log_addr[s0+1], log_data[s0+1]}, 16'h1101);
    gap = log_pulse[s0+1] - fall_pulse[s0];
    chk("dly_gap_lo", 32'(gap >= 12), 1);
    chk("dly_gap_hi", 32'(gap <= 13), 1);
    chk("dly_done", seq_done, 1);

    // Two NACKs then ack.
    load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    s0 = strobe_n; nack_until = s0 + 2;
    pulse_start();
    wait_end("nack2");
    chk("nack2_strobes", strobe_n - s0, 3);
    chk("nack2_w1", {log_addr[s0+1], log_data[s0+1]}, 16'h1280);
    chk("nack2_w2", {log_addr[s0+2], log_data[s0+2]}, 16'h1280);
    chk("nack2_done", seq_done, 1);

    // Four NACKs exhaust the retries.
    s0 = strobe_n; nack_until = s0 + 4;
    pulse_start();
    wait_end("nack4");
    chk("nack4_strobes", strobe_n - s0, 4);
    chk("nack4_err", seq_err, 1);
    chk("nack4_done", seq_done, 0);
    chk("nack4_err_idx", err_idx, 0);
    chk("nack4_busy", seq_busy, 0);

    // No response on the second write; restart from ERR.
    load_rom(16'h1280, 16'h3344, 16'hFFFF, 16'h0000);
    s0 = strobe_n; noresp_at = s0 + 1;
    pulse_start();
    wait_strobe("tmo_a");
    @(negedge clk_sys);
    wait_strobe("tmo_b");
    n = 0;
    while (!seq_err && n < 200) begin @(posedge clk_sys); @(negedge clk_sys); n++; end
    chk("tmo_cycles", n, ACK_TMO);
    chk("tmo_err_idx", err_idx, 1);
    chk("tmo_w1", {log_addr[s0+1], log_data[s0+1]}, 16'h3344);
    noresp_at = 1000;

    // Full table with no end marker: no wrap past the last index.
    load_rom(16'h1280, 16'h1101, 16'h2233, 16'h4455);
    s0 = strobe_n;
    pulse_start();
    wait_end("full");
    repeat (50) @(negedge clk_sys);
    chk("full_strobes", strobe_n - s0, 4);
    chk("full_w3", {log_addr[s0+3], log_data[s0+3]}, 16'h4455);
    chk("full_done", seq_done, 1);
    chk("full_tbl_addr", tbl_addr, 3);

    // Reset while waiting for busy to fall.
    load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    pulse_start();
    wait_strobe("rst");
    repeat (3) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("mid_rst_busy", seq_busy, 0);
    chk("mid_rst_own", own_iic, 0);
    chk("mid_rst_done", seq_done, 0);
    chk("mid_rst_addr", cfg_iic_addr, 0);
    chk("mid_rst_tbl_addr", tbl_addr, 0);
    rst = 1'b0;
    s0 = strobe_n;
    repeat (150) @(negedge clk_sys);
    chk("mid_rst_no_strobe", strobe_n - s0, 0);
    chk("mid_rst_idle", seq_busy, 0);
    chk("act_upper_zero", hi_bits, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
